// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: ATM session FSM (card, language, PIN lockout, withdraw/deposit/inquiry); `ATM_DAY_LIMIT_EN adds a per-session withdraw limit
module atm_session_ctrl #(
  parameter int BAL_W = 8,
  parameter int AMT_W = 6,
  parameter int PIN_W = 4,
  parameter int MAX_TRIES = 3,
  parameter logic [BAL_W-1:0] INIT_BAL = 50,
  parameter logic [PIN_W-1:0] INIT_PIN = 4'b1101,
  parameter int DAY_LIMIT = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_in,
  input  logic             lang_ok,
  input  logic             exit_req,
  input  logic [PIN_W-1:0] pin,
  input  logic             pin_valid,
  input  logic [1:0]       op,
  input  logic             op_valid,
  input  logic [AMT_W-1:0] amount,
  input  logic             amt_valid,
  output logic [BAL_W-1:0] balance_out,
  output logic             txn_done,
  output logic [1:0]       txn_err,
  output logic             card_eject,
  output logic             locked,
  output logic             busy
);
  typedef enum logic [2:0] {S_IDLE, S_LANG, S_PIN, S_MENU, S_AMOUNT, S_EXEC, S_EJECT} state_t;
  state_t state, next;
  logic [BAL_W-1:0] bal, bal_n;
  logic [3:0] tries, tries_inc;
  logic op_q, card_d, exit, pin_ok, pin_bad_last, lim;
  logic [AMT_W-1:0] amt_q;
  logic [BAL_W:0] amt_x, sum;
  logic [1:0] err;
  assign exit = exit_req || !card_in;
  assign pin_ok = pin == INIT_PIN;
  assign tries_inc = tries + 4'd1;
  assign pin_bad_last = !pin_ok && tries_inc >= 4'(MAX_TRIES);
  assign amt_x = (BAL_W+1)'(amt_q);
  assign sum = {1'b0, bal} + amt_x;
  assign bal_n = op_q ? sum[BAL_W-1:0] : bal - amt_x[BAL_W-1:0];
  assign err = op_q ? {sum[BAL_W], 1'b0} : lim ? 2'b11 : {1'b0, amt_x > {1'b0, bal}};
`ifdef ATM_DAY_LIMIT_EN
  logic [BAL_W:0] acc;
  assign lim = ({1'b0, acc} + {1'b0, amt_x}) > (BAL_W+2)'(DAY_LIMIT);
  always_ff @(posedge clk) begin
    if (rst || state == S_EJECT) acc <= '0;
    else if (state == S_EXEC && !op_q && err == 2'b00) acc <= acc + amt_x;
  end
`else
  assign lim = 1'b0;
`endif
  always_comb begin
    next = state;
    case (state)
      S_IDLE:   next = card_in && !locked ? S_LANG : S_IDLE;
      S_LANG:   next = exit ? S_EJECT : lang_ok ? S_PIN : S_LANG;
      S_PIN:    next = exit ? S_EJECT : !pin_valid ? S_PIN : pin_ok ? S_MENU : pin_bad_last ? S_EJECT : S_PIN;
      S_MENU:   next = exit ? S_EJECT : !op_valid ? S_MENU : op == 2'b11 ? S_EJECT : !op[1] ? S_AMOUNT : S_MENU;
      S_AMOUNT: next = exit ? S_EJECT : amt_valid && amount != '0 ? S_EXEC : S_AMOUNT;
      S_EXEC:   next = S_MENU;
      S_EJECT:  next = S_IDLE;
      default:  next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      bal <= INIT_BAL;
      tries <= '0;
      op_q <= 1'b0;
      amt_q <= '0;
      card_d <= 1'b0;
      balance_out <= '0;
      txn_done <= 1'b0;
      txn_err <= 2'b00;
      card_eject <= 1'b0;
      locked <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= next;
      busy <= next != S_IDLE;
      card_d <= card_in;
      txn_done <= 1'b0;
      card_eject <= 1'b0;
      // a locked controller refuses each fresh insertion with one eject pulse
      if (state == S_IDLE && locked && card_in && !card_d) card_eject <= 1'b1;
      if (state == S_PIN && !exit && pin_valid) begin
        tries <= pin_ok ? '0 : tries_inc;
        if (pin_bad_last) locked <= 1'b1;
      end
      if (state == S_MENU && !exit && op_valid) begin
        op_q <= op[0];
        if (op == 2'b10) begin
          balance_out <= bal;
          txn_done <= 1'b1;
          txn_err <= 2'b00;
        end
      end
      if (state == S_AMOUNT) amt_q <= amount;
      if (state == S_EXEC) begin
        txn_done <= 1'b1;
        txn_err <= err;
        if (err == 2'b00) begin
          bal <= bal_n;
          balance_out <= bal_n;
        end
      end
      if (state == S_EJECT) begin
        card_eject <= 1'b1;
        if (!locked) tries <= '0;
      end
    end
  end
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: directed plan plus random strobes checked every cycle against a session-level model
module tb_atm_session_ctrl;
  localparam int INIT_BAL = 50, MAX_TRIES = 3, DAY_LIMIT = 40, BAL_LIM = 256;
  logic clk = 0, rst = 1, card_in = 0, lang_ok = 0, exit_req = 0, pin_valid = 0, op_valid = 0, amt_valid = 0;
  logic [3:0] pin = 0;
  logic [1:0] op = 0;
  logic [5:0] amount = 0;
  logic [7:0] balance_out;
  logic txn_done, card_eject, locked, busy;
  logic [1:0] txn_err;
  int checks = 0, failures = 0;
  atm_session_ctrl dut (.clk(clk), .rst(rst), .card_in(card_in), .lang_ok(lang_ok), .exit_req(exit_req),
    .pin(pin), .pin_valid(pin_valid), .op(op), .op_valid(op_valid), .amount(amount), .amt_valid(amt_valid),
    .balance_out(balance_out), .txn_done(txn_done), .txn_err(txn_err), .card_eject(card_eject),
    .locked(locked), .busy(busy));
  always #5 clk = ~clk;
  task automatic cmp(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  // session-level model: where the user is, what the account holds, what the outputs must show
  string m_st = "idle";
  int m_bal = INIT_BAL, m_tries = 0, m_acc = 0, m_op = 0, m_amt = 0, e_bo = 0, e_err = 0;
  bit m_locked = 0, m_prev = 0, e_done = 0, e_eject = 0, e_busy = 0, m_valid = 0;
  always @(posedge clk) begin
    string nx;
    int er;
    bit ex;
    ex = exit_req || !card_in;
    e_done = 0;
    e_eject = 0;
    nx = m_st;
    if (rst) begin
      nx = "idle"; m_bal = INIT_BAL; m_tries = 0; m_acc = 0; m_locked = 0; e_bo = 0; e_err = 0; m_valid = 1;
    end else if (m_st == "idle") begin
      if (m_locked && card_in && !m_prev) e_eject = 1;
      if (card_in && !m_locked) nx = "lang";
    end else if (m_st == "exec") begin
      er = 0;
      if (m_op == 1) begin
        if (m_bal + m_amt >= BAL_LIM) er = 2;
      end else begin
`ifdef ATM_DAY_LIMIT_EN
        if (m_acc + m_amt > DAY_LIMIT) er = 3; else
`endif
        if (m_amt > m_bal) er = 1;
      end
      if (er == 0) begin
        m_bal = (m_op == 1) ? m_bal + m_amt : m_bal - m_amt;
        if (m_op == 0) m_acc += m_amt;
        e_bo = m_bal;
      end
      e_done = 1; e_err = er; nx = "menu";
    end else if (m_st == "eject") begin
      e_eject = 1; m_acc = 0; nx = "idle";
      if (!m_locked) m_tries = 0;
    end else if (ex) nx = "eject";
    else if (m_st == "lang") begin
      if (lang_ok) nx = "pin";
    end else if (m_st == "pin") begin
      if (pin_valid && pin == 4'b1101) begin m_tries = 0; nx = "menu"; end
      else if (pin_valid) begin
        m_tries++;
        if (m_tries >= MAX_TRIES) begin m_locked = 1; nx = "eject"; end
      end
    end else if (m_st == "menu") begin
      if (op_valid && op < 2) begin m_op = op; nx = "amount"; end
      else if (op_valid && op == 2) begin e_done = 1; e_err = 0; e_bo = m_bal; end
      else if (op_valid) nx = "eject";
    end else if (m_st == "amount") begin
      if (amt_valid && amount != 0) begin m_amt = amount; nx = "exec"; end
    end
    m_st = nx;
    e_busy = (nx != "idle");
    m_prev = rst ? 1'b0 : card_in;
  end
  always @(negedge clk) if (m_valid) begin
    cmp("balance_out", balance_out, e_bo);
    cmp("txn_done", txn_done, e_done);
    cmp("txn_err", txn_err, e_err);
    cmp("card_eject", card_eject, e_eject);
    cmp("locked", locked, m_locked);
    cmp("busy", busy, e_busy);
  end
  task automatic tick(); @(negedge clk); endtask
  task automatic do_lang(); lang_ok = 1; tick(); lang_ok = 0; endtask
  task automatic do_pin(input logic [3:0] v); pin = v; pin_valid = 1; tick(); pin_valid = 0; endtask
  task automatic do_op(input logic [1:0] v); op = v; op_valid = 1; tick(); op_valid = 0; endtask
  task automatic do_amt(input logic [5:0] v); amount = v; amt_valid = 1; tick(); amt_valid = 0; endtask
  task automatic session(); card_in = 1; tick(); do_lang(); do_pin(4'b1101); endtask
  task automatic txn(input logic [1:0] o, input logic [5:0] a, input int bo, input int er, input string n);
    do_op(o); do_amt(a); tick();
    cmp({n, " done"}, txn_done, 1);
    cmp({n, " err"}, txn_err, er);
    cmp({n, " bal"}, balance_out, bo);
  endtask
  task automatic inquiry(input int bo, input string n);
    do_op(2'b10);
    cmp({n, " done"}, txn_done, 1);
    cmp({n, " bal"}, balance_out, bo);
  endtask
  initial begin
    tick(); tick(); rst = 0;
    cmp("reset balance_out", balance_out, 0);
    cmp("reset busy", busy, 0);
    cmp("reset locked", locked, 0);
    session();
    inquiry(50, "inq50");
    txn(0, 20, 30, 0, "wd20");
    txn(1, 30, 60, 0, "dep30");
    txn(0, 10, 50, 0, "wd10");
    txn(0, 51, 50, 1, "wd51");
    inquiry(50, "inq after short");
    txn(1, 63, 113, 0, "dep63a");
    txn(1, 63, 176, 0, "dep63b");
    txn(1, 63, 239, 0, "dep63c");
    txn(1, 63, 239, 2, "dep63 ovf");
    do_op(2'b11); tick();
    cmp("exit eject", card_eject, 1);
    card_in = 0; tick();
    card_in = 1; tick(); do_lang();
    do_pin(0); do_pin(1); do_pin(2);
    cmp("lock set", locked, 1);
    tick();
    cmp("lock eject", card_eject, 1);
    card_in = 0; tick(); card_in = 1; tick();
    cmp("refuse eject", card_eject, 1);
    cmp("refuse busy", busy, 0);
    tick();
    cmp("refuse idle", busy, 0);
    rst = 1; tick(); rst = 0;
    cmp("rst unlock", locked, 0);
`ifdef ATM_DAY_LIMIT_EN
    session();
    txn(0, 30, 20, 0, "lim wd30");
    txn(0, 20, 20, 3, "lim wd20");
    do_op(2'b11); card_in = 0; tick(); tick();
    session();
    txn(0, 20, 0, 0, "lim new session");
    rst = 1; tick(); rst = 0;
`endif
    session(); do_op(2'b00);
    rst = 1; tick(); rst = 0;
    cmp("mid rst busy", busy, 0);
    cmp("mid rst done", txn_done, 0);
    cmp("mid rst eject", card_eject, 0);
    session();
    inquiry(50, "post rst inq");
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) card_in = !card_in;
      lang_ok = ($urandom_range(0, 3) == 0);
      exit_req = ($urandom_range(0, 29) == 0);
      pin_valid = ($urandom_range(0, 2) == 0);
      pin = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1101;
      op_valid = ($urandom_range(0, 2) == 0);
      op = 2'($urandom);
      amt_valid = ($urandom_range(0, 2) == 0);
      amount = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
      tick();
    end
    rst = 0; lang_ok = 0; exit_req = 0; pin_valid = 0; op_valid = 0; amt_valid = 0;
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Parametrised ATM session controller: card insertion, language selection, PIN verification with lockout, and withdraw/deposit/inquiry transactions against a single held account balance. All inputs are qualified by strobes, and all outputs are registered. It is the next-generation replacement for the fixed-width ATM FSM and sits between the keypad/card front end and the display/dispenser logic.

## Interface
- `BAL_W`, 8, balance register width (unsigned).
- `AMT_W`, 6, transaction amount width (`AMT_W <= BAL_W`).
- `PIN_W`, 4, PIN width.
- `MAX_TRIES`, 3, wrong-PIN attempts before lockout (1..15).
- `INIT_BAL`, 50, balance loaded at reset.
- `INIT_PIN`, 4'b1101, PIN loaded at reset.
- `DAY_LIMIT`, 40, cumulative withdraw limit per session (used only with `ATM_DAY_LIMIT_EN`).

Ports:
- `clk`, in, 1, clock. One clock domain; all state changes on its rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `card_in`, in, 1, card present (level).
- `lang_ok`, in, 1, language-chosen strobe.
- `exit_req`, in, 1, user exit strobe; accepted in any non-IDLE state.
- `pin`, in, `PIN_W`, entered PIN; sampled when `pin_valid` is high.
- `pin_valid`, in, 1, PIN entry strobe.
- `op`, in, 2, operation select: 00 withdraw, 01 deposit, 10 inquiry, 11 exit; sampled when `op_valid` is high.
- `op_valid`, in, 1, operation strobe.
- `amount`, in, `AMT_W`, transaction amount; sampled when `amt_valid` is high.
- `amt_valid`, in, 1, amount strobe.
- `balance_out`, out, `BAL_W`, balance snapshot; updated on inquiry and after each successful transaction.
- `txn_done`, out, 1, one-cycle pulse at transaction completion.
- `txn_err`, out, 2, error code, valid with `txn_done`: 00 ok, 01 insufficient funds, 10 overflow, 11 limit exceeded.
- `card_eject`, out, 1, one-cycle pulse when the session ends.
- `locked`, out, 1, level; set after `MAX_TRIES` wrong PINs, cleared only by `rst`.
- `busy`, out, 1, high in every state except IDLE.

## Operation
- States: IDLE, LANG, PIN, MENU, AMOUNT, EXEC, EJECT.
- IDLE → LANG when `card_in` is high and `locked` is 0.
  - If `locked` is 1, the card is refused: `card_eject` pulses once per rising edge of `card_in`.
- LANG → PIN on `lang_ok`.
- PIN, on `pin_valid`:
  - PIN matches: go to MENU and clear the try counter.
  - PIN wrong: increment the try counter. When the count reaches `MAX_TRIES`, set `locked` and go to EJECT; otherwise stay in PIN.
  - Strobes other than `pin_valid` are ignored.
- MENU, on `op_valid`:
  - 00 or 01: latch `op` and go to AMOUNT.
  - 10: `balance_out` is loaded from balance, `txn_done` pulses with `txn_err`=00, stay in MENU.
  - 11: go to EJECT.
- AMOUNT, on `amt_valid`:
  - `amount` = 0 is ignored (stay in AMOUNT).
  - Nonzero: latch the amount and go to EXEC.
- EXEC (exactly one cycle):
  - Withdraw with amount > balance: balance unchanged, err 01.
  - Deposit where balance + amount ≥ 2^`BAL_W`: balance unchanged, err 10 (no wrap).
  - Otherwise: update balance, load `balance_out`, err 00.
  - Always pulse `txn_done` and return to MENU.
- EJECT (one cycle):
  - Pulse `card_eject`.
  - Clear the try counter unless `locked` is set.
  - Go to IDLE.
- `exit_req` in LANG, PIN, MENU or AMOUNT → EJECT on the next edge. In EXEC, the transaction completes first and the exit is then taken from MENU if `exit_req` is still high.
- Simultaneous strobes: only the strobe relevant to the current state is honoured. `exit_req` has priority over all others.
- `card_in` dropping mid-session is treated as `exit_req`.
- Balance and PIN persist across sessions. Only `rst` restores `INIT_BAL` and `INIT_PIN`.
- Arithmetic: amounts are zero-extended to `BAL_W`. The overflow compare uses `BAL_W`+1 bits.

## Timing
- Reset values:
  - State IDLE, balance `INIT_BAL`, try counter 0.
  - `balance_out` 0, `txn_done` 0, `txn_err` 00, `card_eject` 0, `locked` 0, `busy` 0.
- Reset asserted mid-session: everything returns to the reset values on that edge. No `card_eject` or `txn_done` pulse is produced.
- Strobe sampled at edge N: the state changes at edge N.
- Amount accepted at edge N: EXEC at N, and `txn_done`/`balance_out` are valid after edge N+1.
- Inquiry `op_valid` at edge N: `txn_done` and `balance_out` are valid after edge N.
- `txn_err` holds its value until the next `txn_done`.

## Configuration
- `ATM_DAY_LIMIT_EN` defined:
  - A session withdraw accumulator (`BAL_W`+1 bits) is cleared in EJECT and by `rst`.
  - A withdraw whose accumulator + amount > `DAY_LIMIT` fails with err 11 and leaves the balance unchanged. This check has priority over err 01.
  - The accumulator is incremented only on a successful withdraw.
- Undefined: no accumulator logic is present, and err 11 is never produced.

## Test plan
- Reset, card in, `lang_ok`, PIN 1101, op 10 → `balance_out`=50, `txn_done` pulse, err 00.
- Withdraw 20 then deposit 30 → `balance_out` 30 then 60, err 00 both.
- Withdraw 51 from 50 → err 01, balance stays 50.
- Deposit 63 repeatedly from 50 → 113, 176, 239; the next deposit gives err 10 and the balance holds at 239.
- Three wrong PINs → `locked`=1, one `card_eject` pulse. A new card is refused with `card_eject` pulses and never reaches LANG. `rst` clears `locked`.
- With `ATM_DAY_LIMIT_EN`: withdraw 30 then withdraw 20 → second gives err 11 and the balance stays 20. After exit and a new session, withdraw 20 succeeds. Also assert `rst` during AMOUNT → IDLE, balance 50, no pulses.
